rv32_instr_encoder: RTL



---
 rtl/rv32_instr_encoder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder and program loader: range-checks mnemonic/field
// requests, packs them into 32-bit words and writes them to consecutive addresses.
module rv32_instr_encoder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              err_sticky,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d, err_q, err_d, sticky_q, sticky_d, done_q, done_d;

  logic signed [31:0] imm_s;
  logic               fits_i, fits_sh, fits_b, fits_j, fits_u;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [31:0]        enc_word;
  logic               enc_ok;

  assign imm_s   = imm;
  assign fits_i  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fits_sh = (imm[31:5] == '0);
  assign fits_b  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
  assign fits_j  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
  assign fits_u  = (imm[11:0] == '0);

  // funct3/funct7 are shared between the R and I-ALU mnemonics and the memory/branch ops
  always_comb begin
    f3 = 3'b000;
    f7 = 7'h00;
    case (op_sel)
      5'd5, 5'd14, 5'd22:              f3 = 3'b001;
      5'd8, 5'd17, 5'd19, 5'd20:       f3 = 3'b010;
      5'd9, 5'd18:                     f3 = 3'b011;
      5'd4, 5'd13:                     f3 = 3'b100;
      5'd6, 5'd7, 5'd15, 5'd16:        f3 = 3'b101;
      5'd3, 5'd12:                     f3 = 3'b110;
      5'd2, 5'd11:                     f3 = 3'b111;
      default:                         f3 = 3'b000;
    endcase
    if (op_sel == 5'd1 || op_sel == 5'd7 || op_sel == 5'd16) f7 = 7'h20;
  end

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (op_sel) inside
      [5'd0:5'd9]: begin
        enc_word = {f7, rs2, rs1, f3, rd, 7'h33};
        enc_ok   = 1'b1;
      end
      [5'd10:5'd13], 5'd17, 5'd18: begin
        enc_word = {imm[11:0], rs1, f3, rd, 7'h13};
        enc_ok   = fits_i;
      end
      [5'd14:5'd16]: begin
        enc_word = {f7, imm[4:0], rs1, f3, rd, 7'h13};
        enc_ok   = fits_sh;
      end
      5'd19: begin
        enc_word = {imm[11:0], rs1, f3, rd, 7'h03};
        enc_ok   = fits_i;
      end
      5'd20: begin
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
        enc_ok   = fits_i;
      end
      5'd21, 5'd22: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
        enc_ok   = fits_b;
      end
      5'd23: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
        enc_ok   = fits_j;
      end
      5'd24: begin
        enc_word = {imm[11:0], rs1, 3'b000, rd, 7'h67};
        enc_ok   = fits_i;
      end
      5'd25: begin
        enc_word = {imm[31:12], rd, 7'h37};
        enc_ok   = fits_u;
      end
      5'd26: begin
        enc_word = {imm[31:12], rd, 7'h17};
        enc_ok   = fits_u;
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  // The write address is the pre-increment count; FULL stops it from wrapping.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sticky_d = sticky_q;
    we_d     = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    if (start) begin
      state_d  = S_RUN;
      count_d  = '0;
      sticky_d = 1'b0;
    end else begin
      if (in_valid && state_q == S_RUN) begin
        if (enc_ok) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = enc_word;
          count_d = count_q + 1'b1;
          if (count_d == DEPTH) state_d = S_FULL;
        end else begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
        end
      end
      if (finish && state_q != S_IDLE) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
    end
  end

  assign in_ready   = (state_q == S_RUN);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign done       = done_q;

endmodule
